// File: rtl/dp_param.sv
// dp_param: WIDTH-bit accumulator ALU with DEPTH-entry register file, C/Z/N/V flags, valid/ready command port and bit-serial shifts
module dp_param #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int RW = (DEPTH > 2) ? $clog2(DEPTH) : 1,
  localparam int SW = $clog2(WIDTH)
) (
  input  logic             clka,
  input  logic             restart_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       opcode,
  input  logic [RW-1:0]    rsel,
  input  logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] acc_out,
  output logic [WIDTH-1:0] reg_out,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v,
  output logic             done
);
  localparam logic [3:0] NOP  = 4'h0;
  localparam logic [3:0] LDA  = 4'h1;
  localparam logic [3:0] LDR  = 4'h2;
  localparam logic [3:0] STA  = 4'h3;
  localparam logic [3:0] ADD  = 4'h4;
  localparam logic [3:0] ADDI = 4'h5;
  localparam logic [3:0] SUB  = 4'h6;
  localparam logic [3:0] SUBI = 4'h7;
  localparam logic [3:0] ANDR = 4'h8;
  localparam logic [3:0] ORR  = 4'h9;
  localparam logic [3:0] XORR = 4'hA;
  localparam logic [3:0] NOTR = 4'hB;
  localparam logic [3:0] SHL  = 4'hC;
  localparam logic [3:0] SHR  = 4'hD;
  localparam logic [3:0] ADC  = 4'hE;
  localparam logic [3:0] CLRF = 4'hF;
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, reg_out_q, reg_out_d, r_val, arith_b;
  logic [WIDTH-1:0] rf_q [DEPTH];
  logic [WIDTH-1:0] rf_d [DEPTH];
  logic [SW-1:0] count_q, count_d, k;
  logic dir_q, dir_d, c_q, c_d, z_q, z_d, n_q, n_d, v_q, v_d, done_q, done_d;
  logic accept, rsel_ok, shift_multi, is_sub, ovf, upd_zn, last_step;
  logic [WIDTH:0] sum;
  assign accept      = op_valid && op_ready;
  assign k           = imm[SW-1:0];
  assign rsel_ok     = int'(rsel) < DEPTH;
  assign r_val       = rsel_ok ? rf_q[rsel] : '0;
  assign shift_multi = (opcode == SHL || opcode == SHR) && k != '0;
  assign last_step   = count_q == SW'(1);
  assign arith_b     = (opcode == ADDI || opcode == SUBI) ? imm : r_val;
  assign is_sub      = opcode == SUB || opcode == SUBI;
  // the extra top bit is carry-out for adds and borrow for subtracts
  assign sum = is_sub ? {1'b0, acc_q} - {1'b0, arith_b}
                      : {1'b0, acc_q} + {1'b0, arith_b} + {{WIDTH{1'b0}}, opcode == ADC && c_q};
  assign ovf = (is_sub ? acc_q[WIDTH-1] ^ arith_b[WIDTH-1] : ~(acc_q[WIDTH-1] ^ arith_b[WIDTH-1]))
               && (sum[WIDTH-1] ^ acc_q[WIDTH-1]);
  always_comb begin
    state_d = state_q;
    if (state_q == SHIFT) state_d = last_step ? IDLE : SHIFT;
    else if (accept && shift_multi) state_d = SHIFT;
  end
  always_comb op_ready = restart_n && state_q == IDLE;
  always_comb begin
    acc_d     = acc_q;
    rf_d      = rf_q;
    c_d       = c_q;
    z_d       = z_q;
    n_d       = n_q;
    v_d       = v_q;
    count_d   = count_q;
    dir_d     = dir_q;
    done_d    = 1'b0;
    upd_zn    = 1'b0;
    reg_out_d = r_val;
    if (state_q == SHIFT) begin
      acc_d   = dir_q ? acc_q >> 1 : acc_q << 1;
      c_d     = dir_q ? acc_q[0] : acc_q[WIDTH-1];
      count_d = count_q - SW'(1);
      if (last_step) begin
        done_d = 1'b1;
        upd_zn = 1'b1;
        v_d    = 1'b0;
      end
    end else if (accept) begin
      done_d = !shift_multi;
      case (opcode)
        LDA: begin
          acc_d  = imm;
          upd_zn = 1'b1;
        end
        LDR: if (rsel_ok) rf_d[rsel] = imm;
        STA: if (rsel_ok) rf_d[rsel] = acc_q;
        ADD, ADDI, SUB, SUBI, ADC: begin
          acc_d  = sum[WIDTH-1:0];
          c_d    = sum[WIDTH];
          v_d    = ovf;
          upd_zn = 1'b1;
        end
        ANDR, ORR, XORR, NOTR: begin
          acc_d  = opcode == ANDR ? acc_q & r_val :
                   opcode == ORR  ? acc_q | r_val :
                   opcode == XORR ? acc_q ^ r_val : ~r_val;
          c_d    = 1'b0;
          v_d    = 1'b0;
          upd_zn = 1'b1;
        end
        SHL, SHR: begin
          count_d = k;
          dir_d   = opcode == SHR;
          v_d     = shift_multi ? v_q : 1'b0;
          upd_zn  = !shift_multi;
        end
        CLRF: begin
          c_d = 1'b0;
          z_d = 1'b0;
          n_d = 1'b0;
          v_d = 1'b0;
        end
        default: ;
      endcase
    end
    if (upd_zn) begin
      z_d = acc_d == '0;
      n_d = acc_d[WIDTH-1];
    end
  end
  always_ff @(posedge clka or negedge restart_n)
    if (!restart_n) state_q <= IDLE;
    else state_q <= state_d;
  always_ff @(posedge clka or negedge restart_n)
    if (!restart_n) begin
      acc_q     <= '0;
      rf_q      <= '{default: '0};
      reg_out_q <= '0;
      count_q   <= '0;
      dir_q     <= 1'b0;
      c_q       <= 1'b0;
      z_q       <= 1'b0;
      n_q       <= 1'b0;
      v_q       <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      rf_q      <= rf_d;
      reg_out_q <= reg_out_d;
      count_q   <= count_d;
      dir_q     <= dir_d;
      c_q       <= c_d;
      z_q       <= z_d;
      n_q       <= n_d;
      v_q       <= v_d;
      done_q    <= done_d;
    end
  assign acc_out = acc_q;
  assign reg_out = reg_out_q;
  assign flag_c  = c_q;
  assign flag_z  = z_q;
  assign flag_n  = n_q;
  assign flag_v  = v_q;
  assign done    = done_q;
endmodule

// File: doc/dp_param.md
# dp_param

Parametrised successor to the 8-bit accumulator datapath: a WIDTH-bit accumulator ALU with a DEPTH-entry register file, status flags, a valid/ready command handshake and multi-cycle variable shifts. It sits between the control unit, which issues one opcode per accepted handshake, and the bus/memory side, which supplies immediates and reads registered results. It runs on a single clock, in contrast to the earlier two-phase scheme.

## Interface
- WIDTH, 8, datapath width in bits (≥4).
- DEPTH, 4, register-file entries (≥2); RW = max(1, clog2(DEPTH)); SW = clog2(WIDTH).
- clka  in  1  clock, rising-edge.
- restart_n  in  1  reset. Asynchronous, active-low: assertion takes effect immediately; de-assertion is synchronous to clka.
- op_valid  in  1  command present.
- op_ready  out  1  datapath can accept a command.
- opcode  in  4  operation, see Operation.
- rsel  in  RW  register-file index.
- imm  in  WIDTH  immediate / load data / shift count (low SW bits).
- acc_out  out  WIDTH  accumulator.
- reg_out  out  WIDTH  registered copy of r[rsel].
- flag_c, flag_z, flag_n, flag_v  out  1 each  carry/borrow, zero, negative, signed overflow.
- done  out  1  one-cycle completion pulse.

## Operation
- Accept: op_valid && op_ready at a rising clka edge. When op_ready=0, commands are not accepted; the requester holds them.
- Opcodes (R = r[rsel], A = acc):
  - 0 NOP
  - 1 LDA: A<=imm
  - 2 LDR: R<=imm
  - 3 STA: R<=A
  - 4 ADD: A+R
  - 5 ADDI: A+imm
  - 6 SUB: A−R
  - 7 SUBI: A−imm
  - 8 AND: A&R
  - 9 OR: A|R
  - A XOR: A^R
  - B NOT: A<=~R
  - C SHL: A<<k, logical
  - D SHR: A>>k, logical
  - E ADC: A+R+C
  - F CLRF: all flags<=0
- Arithmetic is WIDTH bits, modulo 2^WIDTH.
  - C for add = carry out of bit WIDTH−1.
  - C for sub = borrow (1 iff A < operand, unsigned).
  - V = two's-complement overflow.
- Flag updates:
  - Arithmetic ops (4–7, E): C, V, Z, N.
  - Logic ops (8–B): Z, N; clear C and V.
  - LDA: Z, N only.
  - Shift: C = last bit shifted out, unchanged if k=0; Z, N at completion; V<=0.
  - NOP, LDR, STA: no flag change.
- Z = (result==0); N = result[WIDTH−1].
- FSM states: IDLE, SHIFT. op_ready = (state==IDLE) and is low during reset.
  - IDLE, accept opcode C/D with k = imm[SW−1:0] ≠ 0: load count=k and direction, go to SHIFT.
  - SHIFT: shift A one bit per edge and decrement count. When count reaches 0, return to IDLE.
  - Shift with k=0 completes as a single-cycle op: A unchanged, C unchanged, Z/N/V updated.
- rsel ≥ DEPTH (non-power-of-2 DEPTH): reads return 0; writes are dropped.
- reg_out <= r[rsel] on every edge, including outside accepts.
- Reset: A, all r[i], flags, reg_out, count <= 0; state=IDLE; done=0. Reset during SHIFT aborts the operation; no done pulse.

## Timing
- Single-cycle ops: result, register write and flags are visible after the accept edge. done=1 for exactly the following cycle.
- Single-cycle ops can be issued back-to-back, one per clock; done then stays high continuously.
- Shift by k≥1: op_ready is low for k cycles after the accept edge. A holds the final value after the k-th edge following accept. done and op_ready rise in the same cycle, so the next accept can occur on that edge.
- reg_out shows an LDR/STA write one edge after the write edge.
- op_valid with op_ready=0 has no effect on state, flags or done.

## Test plan
- Reset and loads (WIDTH=8): assert restart_n=0 mid-run → all outputs 0 and op_ready=0. Release, then LDA 0x7F, LDR r1=0x01 → acc_out=0x7F; reg_out(rsel=1)=0x01 one edge later.
- Arithmetic flags: with acc=0x7F, ADD r1=0x01 → acc_out=0x80, V=1, N=1, C=0, Z=0. With acc=0x00, SUBI 0x01 → acc_out=0xFF, C=1 (borrow), N=1.
- ADC chain: with acc=0xFF, ADD 0x01 gives acc=0x00, C=1, Z=1. Then LDA 0x10 (C retained), ADC r=0x01 → acc_out=0x12.
- Multi-cycle shift: acc=0x81, SHL imm=3 → op_ready low 3 cycles, acc_out=0x08, C=0, done one pulse. A second op held on op_valid is accepted only on the edge when op_ready returns.
- Boundary shift: SHR imm=0 → single-cycle, acc unchanged, done next cycle. SHR imm=7 on 0x80 → acc_out=0x01, C=0.
- Reset mid-shift: assert restart_n during cycle 2 of SHL imm=5 → immediate zeroing, state IDLE, no done pulse. The first command after release executes normally.
